// File: rtl/lock_pkg.sv
// Shared state encoding, defaults and timer sizing for the keypad lock sequencer.
package lock_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRead    = 3'd1,
        StCmp     = 3'd2,
        StOpen    = 3'd3,
        StProg    = 3'd4,
        StCommit  = 3'd5,
        StLockout = 3'd6
    } lock_state_e;

    localparam int unsigned DIGIT_W_DEF     = 4;
    localparam int unsigned CODE_LEN_DEF    = 3;
    localparam int unsigned UNLOCK_CYC_DEF  = 500;
    localparam int unsigned LOCKOUT_CYC_DEF = 1000;

    // Bits needed to hold the larger of the two timer reload values.
    function automatic int unsigned timer_w(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock window and the lockout period.
module lock_timer
    import lock_pkg::*;
#(
    parameter int unsigned TW = 10
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] value,
    input  logic          freeze,
    output logic          expired
);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (!freeze && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of N yields exactly N cycles before the state leaves on this pulse.
    assign expired = !freeze && !load && (count_q == TW'(1));

endmodule

// File: rtl/lock_seq_ctrl.sv
// Keypad lock sequencer: digit-by-digit compare against the code RAM, timed unlock,
// in-session reprogramming of the code and a timed lockout after repeated failures.
module lock_seq_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned DIGIT_W     = DIGIT_W_DEF,
    parameter int unsigned CODE_LEN    = CODE_LEN_DEF,
    parameter int unsigned AW          = 2,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned UNLOCK_CYC  = UNLOCK_CYC_DEF,
    parameter int unsigned LOCKOUT_CYC = LOCKOUT_CYC_DEF
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               prog,
    output logic [AW-1:0]      ram_addr,
    output logic               ram_we,
    output logic [DIGIT_W-1:0] ram_wdata,
    input  logic [DIGIT_W-1:0] ram_rdata,
    output logic               enable,
    output logic               error,
    output logic               busy,
    output logic [1:0]         fail_cnt
);

    localparam int unsigned   TW           = timer_w(UNLOCK_CYC, LOCKOUT_CYC);
    localparam logic [AW-1:0] LAST_IDX     = AW'(CODE_LEN - 1);
    localparam logic [1:0]    MAX_FAIL_CNT = 2'(MAX_FAIL);
    localparam logic [TW-1:0] UNLOCK_VAL   = TW'(UNLOCK_CYC);
    localparam logic [TW-1:0] LOCKOUT_VAL  = TW'(LOCKOUT_CYC);

    lock_state_e        state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               bad_q, bad_d, bad_next;
    logic [1:0]         fail_q, fail_d, fail_inc;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               err_pulse_q, err_pulse_d;
    logic               prog_q;
    logic [DIGIT_W-1:0] shadow_q [CODE_LEN];
    logic [DIGIT_W-1:0] shadow_d [CODE_LEN];
    logic               tmr_load, tmr_freeze, tmr_expired;
    logic [TW-1:0]      tmr_value;

    lock_timer #(
        .TW(TW)
    ) u_timer (
        .CLK    (CLK),
        .reset  (reset),
        .load   (tmr_load),
        .value  (tmr_value),
        .freeze (tmr_freeze),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bad_d       = bad_q;
        fail_d      = fail_q;
        digit_d     = digit_q;
        err_pulse_d = 1'b0;
        shadow_d    = shadow_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        tmr_freeze  = 1'b0;
        bad_next    = bad_q | (ram_rdata != digit_q);
        fail_inc    = (fail_q == MAX_FAIL_CNT) ? fail_q : fail_q + 2'd1;

        unique case (state_q)
            StIdle: begin
                if (key_valid && !prog) begin
                    digit_d = key_digit;
                    state_d = StRead;
                end
            end
            StRead: state_d = StCmp;
            StCmp: begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    bad_d   = bad_next;
                    state_d = StIdle;
                end else begin
                    idx_d = '0;
                    bad_d = 1'b0;
                    if (!bad_next) begin
                        fail_d    = '0;
                        tmr_load  = 1'b1;
                        tmr_value = UNLOCK_VAL;
                        state_d   = StOpen;
                    end else begin
                        fail_d      = fail_inc;
                        err_pulse_d = 1'b1;
                        if (fail_inc == MAX_FAIL_CNT) begin
                            tmr_load  = 1'b1;
                            tmr_value = LOCKOUT_VAL;
                            state_d   = StLockout;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StOpen: begin
                // Expiry outranks a coincident program request.
                if (tmr_expired) begin
                    state_d = StIdle;
                end else if (prog && !prog_q) begin
                    state_d = StProg;
                end
            end
            StProg: begin
                tmr_freeze = 1'b1;
                if (!prog) begin
                    idx_d    = '0;
                    shadow_d = '{default: '0};
                    state_d  = StIdle;
                end else if (key_valid) begin
                    shadow_d[idx_q] = key_digit;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = StCommit;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StCommit: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StLockout: begin
                if (tmr_expired) begin
                    fail_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            bad_q       <= 1'b0;
            fail_q      <= '0;
            digit_q     <= '0;
            err_pulse_q <= 1'b0;
            prog_q      <= 1'b0;
            shadow_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bad_q       <= bad_d;
            fail_q      <= fail_d;
            digit_q     <= digit_d;
            err_pulse_q <= err_pulse_d;
            prog_q      <= prog;
            shadow_q    <= shadow_d;
        end
    end

    always_comb begin
        ram_addr  = idx_q;
        ram_we    = 1'b0;
        ram_wdata = '0;
        enable    = 1'b0;
        error     = err_pulse_q;
        busy      = 1'b0;
        unique case (state_q)
            StRead, StCmp: busy = 1'b1;
            StOpen, StProg: enable = 1'b1;
            StCommit: begin
                // Reset kills the write in the very cycle it is asserted.
                ram_we    = !reset;
                ram_wdata = shadow_q[idx_q];
                enable    = 1'b1;
                busy      = 1'b1;
            end
            StLockout: begin
                error = 1'b1;
                busy  = 1'b1;
            end
            default: ;
        endcase
    end

    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl: a per-cycle vector table plus hand-timed corner sequences.
module tb_lock_seq_ctrl;

    localparam int UNLOCK  = 500;
    localparam int LOCKOUT = 1000;

    logic       CLK = 1'b0;
    logic       reset, key_valid, prog, ram_load;
    logic [3:0] key_digit;
    logic [1:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_wdata, ram_rdata;
    logic       enable, error, busy;
    logic [1:0] fail_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;

    typedef struct packed {
        logic       kv;
        logic [3:0] kd;
        logic       pg;
        logic       en;
        logic       er;
        logic       bz;
        logic [1:0] fc;
    } vec_t;

    vec_t vecs[$];

    lock_seq_ctrl #(
        .DIGIT_W    (4),
        .CODE_LEN   (3),
        .AW         (2),
        .MAX_FAIL   (3),
        .UNLOCK_CYC (UNLOCK),
        .LOCKOUT_CYC(LOCKOUT)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .prog     (prog),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .enable   (enable),
        .error    (error),
        .busy     (busy),
        .fail_cnt (fail_cnt)
    );

    initial forever #5 CLK = ~CLK;

    // Code RAM with registered read; ram_load restores the code 3,7,1.
    logic [3:0] mem [4];
    always @(posedge CLK) begin
        if (ram_load) begin
            mem[0] <= 4'd3;
            mem[1] <= 4'd7;
            mem[2] <= 4'd1;
            mem[3] <= 4'd0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge CLK) begin
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_enable"}, enable, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fail_cnt"}, fail_cnt, 0);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
    endtask

    function automatic vec_t mk(input logic kv, input logic [3:0] kd, input logic pg,
                                input logic en, input logic er, input logic bz,
                                input logic [1:0] fc);
        vec_t v;
        v.kv = kv;
        v.kd = kd;
        v.pg = pg;
        v.en = en;
        v.er = er;
        v.bz = bz;
        v.fc = fc;
        return v;
    endfunction

    // Each row drives one cycle of inputs; its expectations are the outputs of the next cycle.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            key_valid = vecs[i].kv;
            key_digit = vecs[i].kd;
            prog      = vecs[i].pg;
            cyc();
            check($sformatf("vec%0d_enable", i), enable, vecs[i].en);
            check($sformatf("vec%0d_error", i), error, vecs[i].er);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].bz);
            check($sformatf("vec%0d_fail_cnt", i), fail_cnt, vecs[i].fc);
        end
        key_valid = 1'b0;
        key_digit = 4'd0;
        prog      = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cyc();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    // Returns observing the cycle three after the final key.
    task automatic enter_code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        press(a);
        cyc();
        cyc();
        press(b);
        cyc();
        cyc();
        press(c);
        cyc();
        cyc();
    endtask

    // Counts enable-high cycles from the current one; optionally raises prog in the last one.
    task automatic wait_open(input logic raise_at_end, output int cnt);
        cnt = 1;
        while (enable && cnt < UNLOCK + 100) begin
            if (raise_at_end && cnt == UNLOCK) prog = 1'b1;
            cyc();
            if (enable) cnt++;
        end
        prog = 1'b0;
    endtask

    initial begin
        int cnt;
        int we0;
        int busy_gap;

        reset     = 1'b1;
        ram_load  = 1'b1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        prog      = 1'b0;

        // Correct code 3,7,1 with keys 4 cycles apart.
        vecs.push_back(mk(1, 3, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        // Key with prog high in idle is ignored, then wrong code 3,5,1.
        vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));

        cyc();
        cyc();
        check_zero("reset_hold");
        reset    = 1'b0;
        ram_load = 1'b0;
        cyc();
        check_zero("after_reset");

        run_vecs(0, 10);
        wait_open(1'b0, cnt);
        check("open_window_len", cnt, UNLOCK);
        check("relocked_enable", enable, 0);
        check("relocked_busy", busy, 0);

        run_vecs(11, 22);

        enter_code(4'd0, 4'd0, 4'd0);
        check("fail2_error", error, 1);
        check("fail2_fail_cnt", fail_cnt, 2);
        check("fail2_busy", busy, 0);

        enter_code(4'd0, 4'd0, 4'd0);
        check("lock_error", error, 1);
        check("lock_busy", busy, 1);
        check("lock_fail_cnt", fail_cnt, 3);
        cnt      = 1;
        busy_gap = 0;
        while (error && cnt < LOCKOUT + 100) begin
            if (!busy) busy_gap++;
            key_valid = (cnt % 100 == 50);
            key_digit = 4'd3;
            cyc();
            if (error) cnt++;
        end
        key_valid = 1'b0;
        check("lockout_len", cnt, LOCKOUT);
        check("lockout_busy_gaps", busy_gap, 0);
        check("post_lock_fail_cnt", fail_cnt, 0);
        check("post_lock_busy", busy, 0);

        enter_code(4'd3, 4'd7, 4'd1);
        check("post_lock_open", enable, 1);
        check("post_lock_open_fc", fail_cnt, 0);

        // Abort: prog falls together with the final digit.
        we0  = we_cnt;
        prog = 1'b1;
        cyc();
        check("abort_prog_enable", enable, 1);
        check("abort_prog_busy", busy, 0);
        press(4'd9);
        press(4'd2);
        key_valid = 1'b1;
        key_digit = 4'd4;
        prog      = 1'b0;
        cyc();
        key_valid = 1'b0;
        check("abort_enable", enable, 0);
        check("abort_busy", busy, 0);
        cyc();
        check("abort_no_writes", we_cnt - we0, 0);
        enter_code(4'd3, 4'd7, 4'd1);
        check("old_code_opens", enable, 1);

        // Program 9,2,4.
        we0  = we_cnt;
        prog = 1'b1;
        cyc();
        check("prog_enable", enable, 1);
        press(4'd9);
        press(4'd2);
        press(4'd4);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("commit%0d_we", k), ram_we, 1);
            check($sformatf("commit%0d_addr", k), ram_addr, k);
            check($sformatf("commit%0d_data", k), ram_wdata, (k == 0) ? 9 : (k == 1) ? 2 : 4);
            check($sformatf("commit%0d_enable", k), enable, 1);
            cyc();
        end
        check("post_commit_we", ram_we, 0);
        check("post_commit_enable", enable, 0);
        check("post_commit_busy", busy, 0);
        prog = 1'b0;
        check("commit_write_count", we_cnt - we0, 3);

        enter_code(4'd9, 4'd2, 4'd4);
        check("new_code_opens", enable, 1);
        wait_open(1'b1, cnt);
        check("expiry_vs_prog_len", cnt, UNLOCK);
        cyc();
        check("expiry_vs_prog_enable", enable, 0);
        check("expiry_vs_prog_busy", busy, 0);

        enter_code(4'd3, 4'd7, 4'd1);
        check("old_code_fails_error", error, 1);
        check("old_code_fails_enable", enable, 0);
        check("old_code_fails_fc", fail_cnt, 1);

        // Reset during compare of the second digit.
        press(4'd9);
        cyc();
        cyc();
        press(4'd2);
        cyc();
        check("cmp2_busy", busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_zero("rst_cmp");
        enter_code(4'd9, 4'd2, 4'd4);
        check("after_rst_cmp_open", enable, 1);

        // Reset during commit.
        we0  = we_cnt;
        prog = 1'b1;
        cyc();
        press(4'd5);
        press(4'd5);
        press(4'd5);
        check("rc_commit0_we", ram_we, 1);
        cyc();
        check("rc_commit1_we", ram_we, 1);
        reset = 1'b1;
        #1;
        check("rc_we_in_reset_cycle", ram_we, 0);
        cyc();
        reset = 1'b0;
        prog  = 1'b0;
        check_zero("rst_commit");
        cyc();
        check("rc_write_count", we_cnt - we0, 1);
        check("total_write_count", we_cnt, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lock_seq_ctrl.md
# lock_seq_ctrl

Sequencing controller for the keypad lock's code RAM. It accepts keypad digits, reads the stored code digit by digit, and compares each entry. On a full match it asserts `enable` for a timed window. While the lock is open it stages and commits a new code when `program` is held. It also counts failed attempts and enforces a timed lockout.

## Interface
Parameters:
- DIGIT_W, 4, width of one code digit
- CODE_LEN, 3, digits per code (2..4)
- AW, 2, RAM address width, ≥ clog2(CODE_LEN)
- MAX_FAIL, 3, consecutive failed attempts before lockout
- UNLOCK_CYC, 500, cycles `enable` stays high
- LOCKOUT_CYC, 1000, lockout duration in cycles

Ports:
- CLK  in  1  single clock; everything is on its rising edge
- reset  in  1  synchronous, active-high
- key_valid  in  1  one-cycle strobe: `key_digit` is valid
- key_digit  in  DIGIT_W  entered digit
- program  in  1  level; request to reprogram the code
- ram_addr  out  AW  code RAM address
- ram_we  out  1  code RAM write strobe
- ram_wdata  out  DIGIT_W  code RAM write data
- ram_rdata  in  DIGIT_W  code RAM read data; registered, 1-cycle latency
- enable  out  1  lock open
- error  out  1  one-cycle pulse on a failed attempt; held high during lockout
- busy  out  1  high when `key_valid` will be ignored
- fail_cnt  out  2  consecutive failed-attempt count

## Operation
- States: IDLE, READ, CMP, OPEN, PROG, COMMIT, LOCKOUT.
- IDLE
  - If `key_valid` and not `program`: capture the digit, drive `ram_addr` = idx, go to READ.
  - If `key_valid` and `program`: ignore the key.
- READ: one wait cycle for the RAM read. Go to CMP.
- CMP
  - Compare `ram_rdata` with the captured digit. A mismatch sets the sticky `bad` flag; no per-digit result is exposed.
  - If idx < CODE_LEN-1: idx++, go to IDLE.
  - Else if `bad` = 0: fail_cnt=0, go to OPEN.
  - Else: fail_cnt++ and pulse `error`. If the new count = MAX_FAIL go to LOCKOUT, otherwise go to IDLE.
  - Every end of attempt clears idx and `bad`.
- OPEN
  - `enable` = 1 and the timer loads UNLOCK_CYC.
  - Timer expiry → IDLE, `enable` = 0.
  - `program` rising (0→1) → PROG, with `enable` still 1.
  - `key_valid` is ignored.
- PROG
  - Each `key_valid` stores the digit in shadow[idx] and increments idx.
  - After CODE_LEN digits → COMMIT.
  - If `program` drops before CODE_LEN digits: discard the shadow, clear idx, go to IDLE (relocked, old code kept).
  - The timer is frozen in PROG.
- COMMIT
  - Runs for CODE_LEN cycles: `ram_we` = 1, `ram_addr` = k, `ram_wdata` = shadow[k] for k = 0..CODE_LEN-1.
  - Then → IDLE with `enable` = 0.
  - Commit is atomic: `program` changes are ignored during it.
- LOCKOUT
  - `error` = 1 and the timer loads LOCKOUT_CYC.
  - On expiry: fail_cnt=0, `error` = 0, go to IDLE.
- `busy` = 1 in READ, CMP, COMMIT and LOCKOUT.
- fail_cnt saturates at MAX_FAIL.

## Timing
- Reset values: state = IDLE, idx = 0, `bad` = 0, fail_cnt = 0, timer = 0, shadow = 0. All outputs are 0.
- Reset mid-COMMIT stops writes that cycle. A partially written code is acceptable; reset takes priority over all events.
- Latency: `key_valid` at cycle n → `ram_addr` valid at n+1 → compare at n+2 → next digit accepted from n+3.
- Final digit at cycle n → `enable` or `error` at n+3.
- `enable` stays high for exactly UNLOCK_CYC cycles when no programming occurs.
- LOCKOUT lasts exactly LOCKOUT_CYC cycles with `error` high.
- COMMIT produces CODE_LEN consecutive `ram_we` cycles. `ram_we` is never high outside COMMIT.
- Simultaneous timer expiry and `program` rising in OPEN: expiry wins and the block goes to IDLE.
- Simultaneous `key_valid` and `program` fall in PROG: the fall wins and the digit is discarded.

## Structure
- Package `lock_pkg`:
  - state encoding (7 states, 3-bit)
  - DIGIT_W and CODE_LEN defaults
  - helper constant for timer width, clog2(max(UNLOCK_CYC, LOCKOUT_CYC)+1)
- Sub-module `lock_timer`: loadable down-counter with `load`, `value`, `freeze` and a one-cycle `expired` output. It is shared by OPEN and LOCKOUT.
- The top holds the FSM, idx, `bad`, fail_cnt and the shadow register.

## Test plan
- RAM = {3,7,1}. Keys 3,7,1 spaced 4 cycles apart → `enable` rises 3 cycles after the last key, stays high for 500 cycles, and fail_cnt = 0.
- RAM = {3,7,1}. Keys 3,5,1 → `error` pulses for exactly one cycle, fail_cnt = 1, `enable` stays 0. Intermediate cycles give no indication of which digit was wrong.
- Three wrong attempts → LOCKOUT: `error` is high and `busy` = 1 for 1000 cycles. Keys during lockout are ignored. After lockout, fail_cnt = 0 and a correct code opens the lock.
- Open the lock, raise `program`, enter 9,2,4 → exactly 3 consecutive `ram_we` cycles with addresses 0,1,2 and data 9,2,4, then `enable` = 0. Keys 9,2,4 then open the lock; keys 3,7,1 fail.
- Open, `program`, enter 9,2, then drop `program` → no `ram_we` occurs, state is IDLE, and the old code 3,7,1 still opens the lock.
- Assert `reset` during CMP of digit 2 and again during COMMIT → all outputs are 0 on the next cycle and idx = 0. In the COMMIT case, `ram_we` is low from the reset cycle onward.
